// File: rtl/map_mem_pkg.sv
// map_mem_pkg: shared types for the mapper-to-memory request arbiter.
package map_mem_pkg;
  localparam int SLOT_ADDR_BITS = 32;
  typedef enum logic {SRC_CPU, SRC_PPU} src_t;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic [SLOT_ADDR_BITS-1:0] addr;
    logic                      we;
    logic [7:0]                wdata;
    logic                      valid;
  } slot_t;
endpackage

// File: rtl/map_mem_arbiter_slot.sv
// map_req_slot: per-side access edge detect feeding a single latest-wins request slot.
module map_req_slot import map_mem_pkg::*; #(
  parameter int ADDR_BITS = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 active_i,
  input  logic                 we_i,
  input  logic [7:0]           wdata_i,
  input  logic                 clr_i,
  output slot_t                slot_o,
  output logic                 overrun_o
);
  logic                 act_q, we_q, ovr_q;
  logic [ADDR_BITS-1:0] addr_q;
  slot_t                slot_q;
  logic                 new_req;
  assign new_req   = active_i && (!act_q || addr_i != addr_q || we_i != we_q);
  assign slot_o    = slot_q;
  assign overrun_o = ovr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      slot_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      act_q  <= active_i;
      we_q   <= we_i;
      addr_q <= addr_i;
      // a capture on the grant edge wins over the clear; the granted entry is not lost
      if (new_req) begin
        slot_q <= '{addr: SLOT_ADDR_BITS'(addr_i), we: we_i, wdata: wdata_i, valid: 1'b1};
        if (slot_q.valid && slot_q.we && !clr_i) ovr_q <= 1'b1;
      end else if (clr_i) begin
        slot_q.valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/map_mem_arbiter.sv
// map_mem_arbiter: serialises mapper PRG (CPU) and CHR (PPU) accesses onto one
// single-port memory controller, one request in flight, PPU first.
module map_mem_arbiter import map_mem_pkg::*; #(
  parameter int                       ADDR_BITS     = 20,
  parameter int                       MEM_ADDR_BITS = 22,
  parameter logic [MEM_ADDR_BITS-1:0] CHR_BASE      = 22'h200000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_BITS-1:0]     prg_addr,
  input  logic                     prg_oe,
  input  logic                     prg_we,
  input  logic [7:0]               cpu_wdata,
  output logic [7:0]               prg_rdata,
  input  logic [ADDR_BITS-1:0]     chr_addr,
  input  logic                     chr_ce,
  input  logic                     chr_oe,
  input  logic                     chr_we,
  input  logic [7:0]               ppu_wdata,
  output logic [7:0]               chr_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  input  logic                     mem_ack,
  input  logic [7:0]               mem_rdata,
  output logic                     overrun
);
  slot_t                    cpu_slot, ppu_slot;
  logic                     cpu_ovr, ppu_ovr, grant_cpu, grant_ppu;
  logic [MEM_ADDR_BITS-1:0] prg_mem_addr, chr_mem_addr;
  state_t                   state_q;
  src_t                     src_q;
  logic                     req_q, we_q;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic [7:0]               wdata_q, prg_rdata_q, chr_rdata_q;
  map_req_slot #(.ADDR_BITS(ADDR_BITS)) u_cpu_slot (
    .clk(clk), .rst_n(rst_n), .addr_i(prg_addr), .active_i(prg_oe | prg_we), .we_i(prg_we),
    .wdata_i(cpu_wdata), .clr_i(grant_cpu), .slot_o(cpu_slot), .overrun_o(cpu_ovr)
  );
  map_req_slot #(.ADDR_BITS(ADDR_BITS)) u_ppu_slot (
    .clk(clk), .rst_n(rst_n), .addr_i(chr_addr), .active_i(chr_ce & (chr_oe | chr_we)),
    .we_i(chr_ce & chr_we), .wdata_i(ppu_wdata), .clr_i(grant_ppu), .slot_o(ppu_slot),
    .overrun_o(ppu_ovr)
  );
  assign grant_ppu    = state_q == IDLE && ppu_slot.valid;
  assign grant_cpu    = state_q == IDLE && !ppu_slot.valid && cpu_slot.valid;
  assign prg_mem_addr = MEM_ADDR_BITS'(cpu_slot.addr);
  assign chr_mem_addr = MEM_ADDR_BITS'(SLOT_ADDR_BITS'(CHR_BASE) + cpu_slot.addr * 0 + ppu_slot.addr);
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign prg_rdata    = prg_rdata_q;
  assign chr_rdata    = chr_rdata_q;
  assign overrun      = cpu_ovr | ppu_ovr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= SRC_CPU;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      prg_rdata_q <= 8'hFF;
      chr_rdata_q <= 8'hFF;
    end else if (grant_ppu || grant_cpu) begin
      state_q <= BUSY;
      req_q   <= 1'b1;
      src_q   <= grant_ppu ? SRC_PPU : SRC_CPU;
      we_q    <= grant_ppu ? ppu_slot.we : cpu_slot.we;
      addr_q  <= grant_ppu ? chr_mem_addr : prg_mem_addr;
      wdata_q <= grant_ppu ? ppu_slot.wdata : cpu_slot.wdata;
    end else if (state_q == BUSY && mem_ack) begin
      // ack edge always returns to IDLE, so consecutive grants are at least one cycle apart
      state_q <= IDLE;
      req_q   <= 1'b0;
      if (!we_q && src_q == SRC_PPU) chr_rdata_q <= mem_rdata;
      if (!we_q && src_q == SRC_CPU) prg_rdata_q <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_map_mem_arbiter.sv
// tb_map_mem_arbiter: directed vectors, corner sequences and random traffic
// against a transaction-level model of the arbiter.
module tb_map_mem_arbiter;
  localparam int CB  = 32'h200000;
  localparam int CB2 = 32'h3FFFF0;
  localparam int MOD = 1 << 22;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [19:0] prg_addr = '0, chr_addr = '0;
  logic        prg_oe = 0, prg_we = 0, chr_ce = 0, chr_oe = 0, chr_we = 0, mem_ack = 0;
  logic [7:0]  cpu_wdata = '0, ppu_wdata = '0, mem_rdata = '0;
  logic [7:0]  prg_rdata, chr_rdata, mem_wdata, prg_rdata2, chr_rdata2, mem_wdata2;
  logic        mem_req, mem_we, overrun, mem_req2, mem_we2, overrun2;
  logic [21:0] mem_addr, mem_addr2;
  int n_cmp = 0, n_fail = 0;
  map_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .prg_addr(prg_addr), .prg_oe(prg_oe), .prg_we(prg_we),
    .cpu_wdata(cpu_wdata), .prg_rdata(prg_rdata), .chr_addr(chr_addr), .chr_ce(chr_ce),
    .chr_oe(chr_oe), .chr_we(chr_we), .ppu_wdata(ppu_wdata), .chr_rdata(chr_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .overrun(overrun)
  );
  map_mem_arbiter #(.CHR_BASE(22'h3FFFF0)) dut2 (
    .clk(clk), .rst_n(rst_n), .prg_addr(prg_addr), .prg_oe(prg_oe), .prg_we(prg_we),
    .cpu_wdata(cpu_wdata), .prg_rdata(prg_rdata2), .chr_addr(chr_addr), .chr_ce(chr_ce),
    .chr_oe(chr_oe), .chr_we(chr_we), .ppu_wdata(ppu_wdata), .chr_rdata(chr_rdata2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .overrun(overrun2)
  );
  always #5 clk = ~clk;
  // model: index 0 = CPU/PRG side, 1 = PPU/CHR side
  bit         m_busy, m_src, m_req, m_we, m_ovr;
  int         m_addr, m_raw;
  logic [7:0] m_wd, m_prg, m_chr;
  bit         h_act[2], h_we[2], q_v[2], q_we[2];
  int         h_addr[2], q_addr[2];
  logic [7:0] q_wd[2];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_src = 0; m_req = 0; m_we = 0; m_ovr = 0; m_addr = 0; m_raw = 0; m_wd = 0;
    m_prg = 8'hFF; m_chr = 8'hFF;
    for (int s = 0; s < 2; s++) begin
      h_act[s] = 0; h_we[s] = 0; h_addr[s] = 0; q_v[s] = 0; q_we[s] = 0; q_addr[s] = 0; q_wd[s] = 0;
    end
  endtask
  task automatic model_step();
    bit act[2], we[2];
    int addr[2];
    logic [7:0] wd[2];
    act[0] = prg_oe | prg_we;              we[0] = prg_we;          addr[0] = int'(prg_addr); wd[0] = cpu_wdata;
    act[1] = chr_ce & (chr_oe | chr_we);   we[1] = chr_ce & chr_we; addr[1] = int'(chr_addr); wd[1] = ppu_wdata;
    if (!m_busy) begin
      for (int s = 1; s >= 0; s--)
        if (q_v[s] && !m_busy) begin
          m_busy = 1; m_req = 1; m_src = s[0]; m_we = q_we[s]; m_raw = q_addr[s]; m_wd = q_wd[s];
          m_addr = s == 1 ? (CB + m_raw) % MOD : m_raw;
          q_v[s] = 0;
        end
    end else if (mem_ack) begin
      m_busy = 0; m_req = 0;
      if (!m_we && m_src) m_chr = mem_rdata;
      if (!m_we && !m_src) m_prg = mem_rdata;
    end
    for (int s = 0; s < 2; s++) begin
      if (act[s] && (!h_act[s] || addr[s] != h_addr[s] || we[s] != h_we[s])) begin
        if (q_v[s] && q_we[s]) m_ovr = 1;
        q_v[s] = 1; q_we[s] = we[s]; q_addr[s] = addr[s]; q_wd[s] = wd[s];
      end
      h_act[s] = act[s]; h_we[s] = we[s]; h_addr[s] = addr[s];
    end
  endtask
  task automatic check_model();
    chk("model mem_req", mem_req, m_req);
    chk("model mem_req2", mem_req2, m_req);
    if (m_req) begin
      chk("model mem_we", mem_we, m_we);
      chk("model mem_addr", mem_addr, m_addr);
      chk("model mem_addr2", mem_addr2, m_src ? (CB2 + m_raw) % MOD : m_raw);
      if (m_we) chk("model mem_wdata", mem_wdata, m_wd);
    end
    chk("model prg_rdata", prg_rdata, m_prg);
    chk("model chr_rdata", chr_rdata, m_chr);
    chk("model overrun", overrun, m_ovr);
  endtask
  task automatic tick();
    if (rst_n) model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
    mem_ack = 0;
  endtask
  task automatic idle_inputs();
    prg_oe = 0; prg_we = 0; chr_ce = 0; chr_oe = 0; chr_we = 0;
  endtask
  task automatic ack(logic [7:0] d);
    mem_rdata = d; mem_ack = 1; tick();
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst mem_req", mem_req, 0);
    chk("rst overrun", overrun, 0);
    chk("rst prg_rdata", prg_rdata, 8'hFF);
    chk("rst chr_rdata", chr_rdata, 8'hFF);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask
  typedef struct {
    logic [19:0] paddr; bit poe, pwe; logic [7:0] pwd;
    bit cce; logic [19:0] caddr; bit coe, cwe; logic [7:0] cwd;
    logic [7:0] rd; logic [21:0] e_addr; bit e_we; logic [7:0] e_wd, e_prg, e_chr;
  } vec_t;
  vec_t vecs[6];
  int cnt, dly;
  initial begin
    vecs[0] = '{20'h04321, 1, 0, 8'h00, 0, 20'h0, 0, 0, 8'h00, 8'hA5, 22'h004321, 0, 8'h00, 8'hA5, 8'hFF};
    vecs[1] = '{20'h0, 0, 0, 8'h00, 1, 20'h01FFF, 0, 1, 8'h3C, 8'h77, 22'h201FFF, 1, 8'h3C, 8'hA5, 8'hFF};
    vecs[2] = '{20'h0, 0, 0, 8'h00, 1, 20'h00010, 1, 0, 8'h00, 8'h5A, 22'h200010, 0, 8'h00, 8'hA5, 8'h5A};
    vecs[3] = '{20'h7FFFF, 1, 1, 8'hC3, 0, 20'h0, 0, 0, 8'h00, 8'h11, 22'h07FFFF, 1, 8'hC3, 8'hA5, 8'h5A};
    vecs[4] = '{20'h0, 0, 0, 8'h00, 1, 20'hFFFFF, 1, 0, 8'h00, 8'h99, 22'h2FFFFF, 0, 8'h00, 8'hA5, 8'h99};
    vecs[5] = '{20'h00000, 1, 0, 8'h00, 0, 20'h0, 0, 0, 8'h00, 8'h00, 22'h000000, 0, 8'h00, 8'h00, 8'h99};
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst prg_rdata", prg_rdata, 8'hFF);
    chk("rst chr_rdata", chr_rdata, 8'hFF);
    chk("rst overrun", overrun, 0);
    rst_n = 1;
    tick();
    // single-side transactions
    foreach (vecs[i]) begin
      prg_addr = vecs[i].paddr; prg_oe = vecs[i].poe; prg_we = vecs[i].pwe; cpu_wdata = vecs[i].pwd;
      chr_ce = vecs[i].cce; chr_addr = vecs[i].caddr; chr_oe = vecs[i].coe; chr_we = vecs[i].cwe;
      ppu_wdata = vecs[i].cwd;
      tick();
      chk("vec req early", mem_req, 0);
      tick();
      chk("vec req", mem_req, 1);
      chk("vec addr", mem_addr, vecs[i].e_addr);
      chk("vec we", mem_we, vecs[i].e_we);
      if (vecs[i].e_we) chk("vec wdata", mem_wdata, vecs[i].e_wd);
      tick();
      chk("vec req held", mem_req, 1);
      ack(vecs[i].rd);
      chk("vec req drop", mem_req, 0);
      chk("vec prg_rdata", prg_rdata, vecs[i].e_prg);
      chk("vec chr_rdata", chr_rdata, vecs[i].e_chr);
      repeat (2) tick();
      chk("vec no repeat", mem_req, 0);
      idle_inputs();
      repeat (2) tick();
    end
    // collision: PPU first, CPU after one idle cycle
    prg_addr = 20'h00100; prg_oe = 1; chr_ce = 1; chr_addr = 20'h00200; chr_oe = 1;
    repeat (2) tick();
    chk("coll ppu addr", mem_addr, 22'h200200);
    ack(8'h12);
    chk("coll chr_rdata", chr_rdata, 8'h12);
    chk("coll gap", mem_req, 0);
    tick();
    chk("coll cpu req", mem_req, 1);
    chk("coll cpu addr", mem_addr, 22'h000100);
    ack(8'h34);
    chk("coll prg_rdata", prg_rdata, 8'h34);
    chk("coll chr keep", chr_rdata, 8'h12);
    idle_inputs();
    repeat (2) tick();
    // overrun: two CHR writes during a CPU transaction
    prg_addr = 20'h00ABC; prg_oe = 1;
    repeat (2) tick();
    chr_ce = 1; chr_we = 1; chr_addr = 20'h00001; ppu_wdata = 8'h11;
    tick();
    chr_addr = 20'h00002; ppu_wdata = 8'h22;
    tick();
    chk("ovr set", overrun, 1);
    ack(8'h56);
    tick();
    chk("ovr ppu addr", mem_addr, 22'h200002);
    chk("ovr ppu wdata", mem_wdata, 8'h22);
    ack(8'h00);
    idle_inputs();
    repeat (4) tick();
    chk("ovr sticky", overrun, 1);
    do_reset();
    tick();
    // two CHR reads in the same situation do not flag overrun
    prg_addr = 20'h00ABD; prg_oe = 1;
    repeat (2) tick();
    chr_ce = 1; chr_oe = 1; chr_addr = 20'h00003;
    tick();
    chr_addr = 20'h00004;
    tick();
    ack(8'h66);
    tick();
    chk("rr ppu addr", mem_addr, 22'h200004);
    ack(8'h77);
    chk("rr chr_rdata", chr_rdata, 8'h77);
    chk("rr overrun", overrun, 0);
    idle_inputs();
    repeat (2) tick();
    // wrap of CHR_BASE + chr_addr
    chr_ce = 1; chr_oe = 1; chr_addr = 20'h00020;
    repeat (2) tick();
    chk("wrap addr2", mem_addr2, 22'h000010);
    ack(8'h01);
    idle_inputs();
    repeat (2) tick();
    // reset while BUSY, then a stray ack
    prg_addr = 20'h00321; prg_oe = 1;
    repeat (2) tick();
    chk("busy before rst", mem_req, 1);
    do_reset();
    mem_ack = 1; mem_rdata = 8'hEE;
    tick();
    chk("late ack req", mem_req, 0);
    chk("late ack prg", prg_rdata, 8'hFF);
    // random traffic against the model
    cnt = 0; dly = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        prg_addr = 20'($urandom_range(0, 3)); prg_oe = 1'($urandom); prg_we = ($urandom_range(0, 3) == 0);
        cpu_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        chr_addr = 20'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 20'hFFFF0 : 20'h0);
        chr_ce = ($urandom_range(0, 4) != 0); chr_oe = 1'($urandom); chr_we = ($urandom_range(0, 3) == 0);
        ppu_wdata = 8'($urandom);
      end
      if (mem_req) begin
        cnt++;
        if (cnt >= dly) begin
          mem_ack = 1; mem_rdata = 8'($urandom); cnt = 0; dly = $urandom_range(1, 4);
        end
      end else begin
        cnt = 0;
        if ($urandom_range(0, 15) == 0) mem_ack = 1;
      end
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
